// File: rtl/aes_buf_pkg.sv
// Shared types and default sizes for the AES result output queue.
//   buf_state_t   : queue controller state (wipe pass or normal run)
//   AES_BUF_WIDTH : default entry width (128-bit block + 2 tag bits)
//   AES_BUF_DEPTH : default number of entries
package aes_buf_pkg;

  typedef enum logic {BUF_WIPE, BUF_RUN} buf_state_t;

  localparam int AES_BUF_WIDTH = 130;
  localparam int AES_BUF_DEPTH = 32;

endpackage

// File: rtl/buf_mem.sv
// Queue storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port. Deliberately not reset; the controller clears it
// with a zeroizing wipe pass instead.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module buf_mem
  import aes_buf_pkg::*;
#(
  parameter int WIDTH = AES_BUF_WIDTH,
  parameter int DEPTH = AES_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aes_output_queue.sv
// AES result output queue: valid/ready FIFO with first-word-fall-through
// output, occupancy / almost-full reporting and a zeroizing flush.
//   clk, rstn          : clock, async active-low reset
//   in_valid/in_ready  : producer handshake, in_data write word
//   out_valid/out_ready: consumer handshake, out_data head word (0 when idle)
//   flush_req          : request discard + zeroize of all entries
//   flush_busy         : wipe pass in progress (also after reset)
//   count              : occupancy; almost_full / full / empty derived from it
module aes_output_queue
  import aes_buf_pkg::*;
#(
  parameter int WIDTH        = AES_BUF_WIDTH,
  parameter int DEPTH        = AES_BUF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  buf_state_t    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wipe_idx_q, wipe_idx_d;
  logic [CW-1:0] count_q, count_d;

  logic             run, push, pop;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  assign run         = (state_q == BUF_RUN);
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign in_ready    = run && !full;
  assign out_valid   = run && !empty;
  assign flush_busy  = !run;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign count       = count_q;

  // Never expose stale storage: gate the head when nothing is valid.
  assign out_data = out_valid ? mem_rdata : '0;

  // Pushes only happen in RUN, so the wipe can own the write port outright.
  assign mem_we    = push || !run;
  assign mem_waddr = run ? wr_ptr_q : wipe_idx_q;
  assign mem_wdata = run ? in_data : '0;

  buf_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wipe_idx_d = wipe_idx_q;
    count_d    = count_q;
    case (state_q)
      BUF_WIPE: begin
        // flush_req is ignored here; a wipe always runs to completion.
        wipe_idx_d = wipe_idx_q + AW'(1);
        if (wipe_idx_q == AW'(DEPTH-1)) begin
          state_d    = BUF_RUN;
          wipe_idx_d = '0;
        end
      end
      BUF_RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
        // Handshakes of this cycle still complete; a word pushed now is
        // written and then zeroized by the wipe.
        if (flush_req) begin
          state_d    = BUF_WIPE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          wipe_idx_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BUF_WIPE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wipe_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wipe_idx_q <= wipe_idx_d;
      count_q    <= count_d;
    end
  end

endmodule
